// File: rtl/vector_loader.sv
// Packs a valid/ready stream of N-bit words into WIDTH_VECTOR-lane vectors
// and strobes each finished vector into the core's vector data memory.
module vector_loader #(
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32,
  parameter int MEM_WA       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MEM_WA-1:0]           base_addr,
  input  logic                        s_valid,
  input  logic [N-1:0]                s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic                        we,
  output logic [MEM_WA-1:0]           waddr,
  output logic [WIDTH_VECTOR*N-1:0]   wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [MEM_WA:0]             vec_count,
  output logic [1:0]                  dbg_state
);

  localparam int VW = WIDTH_VECTOR * N;
  localparam int LW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
  localparam logic [LW-1:0]     LANE_MAX = LW'(WIDTH_VECTOR - 1);
  localparam logic [MEM_WA-1:0] ADDR_MAX = '1;
  localparam logic [MEM_WA-1:0] ADDR_ONE = MEM_WA'(1);
  localparam logic [MEM_WA:0]   CNT_ONE  = (MEM_WA+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on the current state, never on s_valid.

  state_t              state_q, state_d;
  logic [MEM_WA-1:0]   addr_q, addr_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [VW-1:0]       buf_q, buf_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [MEM_WA-1:0]   waddr_q, waddr_d;
  logic [VW-1:0]       wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [MEM_WA:0]     cnt_q, cnt_d;
  logic [VW-1:0]       fill_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // we/waddr/wdata/done are registered, so they are loaded on the transition
  // into the state in which they must be visible.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    buf_d    = buf_q;
    last_d   = last_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    fill_buf = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          addr_d  = base_addr;
          lane_d  = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      FILL: begin
        if (s_valid) begin
          fill_buf[int'(lane_q)*N +: N] = s_data;
          buf_d = fill_buf;
          if (lane_q == LANE_MAX || s_last) begin
            state_d = WRITE;
            last_d  = s_last;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = fill_buf;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      WRITE: begin
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (addr_q == ADDR_MAX) begin
          // Address space exhausted: stop rather than wrap onto base_addr.
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          state_d = FILL;
          addr_d  = addr_q + ADDR_ONE;
          lane_d  = '0;
          buf_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_ready   = (state_q == FILL);
  assign busy      = (state_q != IDLE);
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign vec_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_loader.sv
// Bench for vector_loader: a table of load sessions driven through a
// reference packer, with writes checked by a negedge monitor against exp_q.
module tb_vector_loader;

  localparam int WV = 8;
  localparam int N  = 32;
  localparam int MW = 8;
  localparam int VW = WV * N;
  localparam int W  = MW + VW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] base_addr;
  logic          s_valid;
  logic [N-1:0]  s_data;
  logic          s_last;
  logic          s_ready;
  logic          we;
  logic [MW-1:0] waddr;
  logic [VW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [MW:0]   vec_count;
  logic [1:0]    dbg_state;

  vector_loader #(.WIDTH_VECTOR(WV), .N(N), .MEM_WA(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .overflow(overflow), .vec_count(vec_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] base;
    logic [N-1:0]  first;
    int            n;
    bit            use_last;
    bit            gaps;
    int            exp_vecs;
    bit            exp_ovf;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            we_seen = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;
  vec_t          tbl[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && we === 1'b1) begin
      we_seen++;
      check("ready_low_in_write", W'(s_ready), W'(0));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got write at %0h want no write", waddr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", {waddr, wdata}, mon_exp);
      end
    end
  end

  task automatic run_session(input vec_t v);
    int            k, cyc, acc_cyc, done_cyc, done_n, rdy_n, lane;
    logic [MW-1:0] m_addr;
    logic [VW-1:0] m_buf;
    bit            stopped, fin, vld;
    @(negedge clk);
    start = 1'b1;
    base_addr = v.base;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", W'(busy), W'(1));
    check("start_ovf_clear", W'(overflow), W'(0));
    check("start_cnt_clear", W'(vec_count), W'(0));
    m_addr = v.base; m_buf = '0; lane = 0; k = 0; cyc = 0;
    stopped = 0; fin = 0; acc_cyc = 0;
    while (k < v.n && !stopped && cyc < 400) begin
      @(negedge clk);
      cyc++;
      vld = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_valid = vld;
      s_data  = v.first + N'(k);
      s_last  = v.use_last && (k == v.n - 1);
      if (vld && s_ready) begin
        m_buf[lane*N +: N] = s_data;
        acc_cyc = cyc;
        k++;
        if (lane == WV - 1 || s_last) begin
          exp_q.push_back({m_addr, m_buf});
          if (s_last) fin = 1;
          else if (m_addr == 8'hFF) stopped = 1;
          else begin
            m_addr++;
            m_buf = '0;
            lane = 0;
          end
        end else begin
          lane++;
        end
      end
    end
    if (!fin && !stopped) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got %0d words want %0d", k, v.n);
    end
    done_n = 0; rdy_n = 0; done_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cyc++;
      s_valid = stopped;
      s_last  = 1'b0;
      s_data  = v.first + N'(k);
      if (s_valid && s_ready) rdy_n++;
      if (done) begin
        done_n++;
        done_cyc = cyc;
        check("vec_count", W'(vec_count), W'(v.exp_vecs));
        check("overflow_at_done", W'(overflow), W'(v.exp_ovf));
      end
    end
    s_valid = 1'b0;
    check("done_pulses", W'(done_n), W'(1));
    check("done_latency", W'(done_cyc), W'(acc_cyc + 2));
    check("no_accept_after_end", W'(rdy_n), W'(0));
    check("idle_after_session", W'(busy), W'(0));
    check("overflow_sticky", W'(overflow), W'(v.exp_ovf));
  endtask

  initial begin
    int we_before, rdy_cnt, exp_total;
    tbl[0] = '{base: 8'h10, first: 32'h1,   n: 16, use_last: 1, gaps: 0, exp_vecs: 2, exp_ovf: 0};
    tbl[1] = '{base: 8'h00, first: 32'hA,   n: 3,  use_last: 1, gaps: 0, exp_vecs: 1, exp_ovf: 0};
    tbl[2] = '{base: 8'h10, first: 32'h1,   n: 16, use_last: 1, gaps: 1, exp_vecs: 2, exp_ovf: 0};
    tbl[3] = '{base: 8'hFF, first: 32'h1,   n: 16, use_last: 0, gaps: 0, exp_vecs: 1, exp_ovf: 1};
    tbl[4] = '{base: 8'h40, first: 32'h100, n: 20, use_last: 1, gaps: 1, exp_vecs: 3, exp_ovf: 0};
    tbl[5] = '{base: 8'hFE, first: 32'h55,  n: 9,  use_last: 1, gaps: 0, exp_vecs: 2, exp_ovf: 0};

    rst = 1'b1; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", W'(dbg_state), W'(0));
    check("rst_we", W'(we), W'(0));
    check("rst_waddr_wdata", {waddr, wdata}, W'(0));
    check("rst_flags", W'({busy, done, overflow, s_ready}), W'(0));
    check("rst_vec_count", W'(vec_count), W'(0));
    rst = 1'b0;

    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = N'($urandom);
      if (s_ready) rdy_cnt++;
    end
    s_valid = 1'b0;
    check("idle_ready_never", W'(rdy_cnt), W'(0));
    check("idle_no_we", W'(we_seen), W'(0));
    check("idle_outputs", W'({busy, done, overflow}), W'(0));

    exp_total = 0;
    for (int t = 0; t < 6; t++) begin
      run_session(tbl[t]);
      exp_total += tbl[t].exp_vecs;
    end

    we_before = we_seen;
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h30;
    @(negedge clk);
    start = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 32'hDEAD0000 + N'(i);
      s_last = 1'b0;
      if (s_ready) rdy_cnt++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_words_taken", W'(rdy_cnt), W'(5));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_we", W'(we), W'(0));
    check("midrst_regs", {waddr, wdata}, W'(0));
    check("midrst_count", W'(vec_count), W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_write", W'(we_seen), W'(we_before));
    run_session('{base: 8'h20, first: 32'h200, n: 8, use_last: 1, gaps: 0, exp_vecs: 1, exp_ovf: 0});
    exp_total += 1;

    repeat (3) @(negedge clk);
    check("pending_writes", W'(exp_q.size()), W'(0));
    check("total_writes", W'(we_seen), W'(exp_total));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
